// File: rtl/dm_pkg.sv
// dm_pkg: shared state encoding, counter width and address checking for the memory responders.
package dm_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int CNT_WIDTH = 4;

    // A word access must be aligned and fall inside the 2**aw-word array.
    function automatic logic addr_err(input logic [31:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
    endfunction

endpackage

// File: rtl/dm_ram.sv
// dm_ram: word array with byte-enable synchronous write and two combinational read ports.
module dm_ram #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [31:0]           dbg_data
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];

    assign rdata    = mem[addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/dm_responder.sv
// dm_responder: single-outstanding load/store responder with fixed wait states and a debug read port.
module dm_responder #(
    parameter int ADDR_WIDTH  = 7,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_be,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [31:0]           dbg_data
);
    import dm_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 cool, c_we;
    logic [31:0]          c_addr, c_wdata;
    logic [3:0]           c_be;
    logic                 accept, access, a_we, a_err, ram_we;
    logic [31:0]          a_addr, a_wdata, ram_rdata;
    logic [3:0]           a_be;

    // cool blocks acceptance for the one cycle after a response handshake
    assign req_ready  = (state == IDLE) && !cool;
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign access     = (WAIT_CYCLES == 0) ? accept : (state == WAIT && cnt == '0);

    // with no wait states the access uses the request at its accept edge
    assign a_we    = (WAIT_CYCLES == 0) ? req_we    : c_we;
    assign a_addr  = (WAIT_CYCLES == 0) ? req_addr  : c_addr;
    assign a_wdata = (WAIT_CYCLES == 0) ? req_wdata : c_wdata;
    assign a_be    = (WAIT_CYCLES == 0) ? req_be    : c_be;
    assign a_err   = addr_err(a_addr, ADDR_WIDTH);
    assign ram_we  = rst && access && a_we && !a_err;

    dm_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk      (clk),
        .we       (ram_we),
        .be       (a_be),
        .addr     (a_addr[ADDR_WIDTH+1:2]),
        .wdata    (a_wdata),
        .rdata    (ram_rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? (accept ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE) :
                    (state == WAIT) ? ((cnt == '0) ? RESP : WAIT) :
                    (resp_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            cool       <= 1'b0;
            c_we       <= 1'b0;
            c_addr     <= '0;
            c_wdata    <= '0;
            c_be       <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            cool <= (state == RESP) && resp_ready;
            if (accept) begin
                cnt     <= CNT_INIT;
                c_we    <= req_we;
                c_addr  <= req_addr;
                c_wdata <= req_wdata;
                c_be    <= req_be;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access) begin
                resp_rdata <= (a_we || a_err) ? 32'd0 : ram_rdata;
                resp_err   <= a_err;
            end else if (state == RESP && resp_ready) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: vector table, corner-case sequences and random traffic against a word-array model.
module tb_dm_responder;

    localparam int AW = 7;
    localparam int WC = 2;

    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;

    logic req_valid = 0, req_we = 0, resp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0] req_be = 0;
    logic [AW-1:0] dbg_addr = 0;
    logic req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, dbg_data;

    logic z_req_valid = 0, z_req_we = 0, z_resp_ready = 1;
    logic [31:0] z_req_addr = 0, z_req_wdata = 0;
    logic [3:0] z_req_be = 0;
    logic [AW-1:0] z_dbg_addr = 0;
    logic z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata, z_dbg_data;

    dm_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    dm_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be), .resp_valid(z_resp_valid),
        .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err),
        .dbg_addr(z_dbg_addr), .dbg_data(z_dbg_data)
    );

    int checks = 0;
    int fails = 0;
    logic [31:0] mem_m [128];
    bit known [128];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rd;
        logic        er;
    } vec_t;
    vec_t tbl[20];

    int cyc = 0;
    int z_acc[$];
    int z_rsp[$];
    logic [31:0] z_dat[$];

    // zero-wait instance is driven just after rising edges and observed on falling edges
    always @(negedge clk) begin
        cyc++;
        if (z_req_valid && z_req_ready) z_acc.push_back(cyc);
        if (z_resp_valid && z_resp_ready) begin
            z_rsp.push_back(cyc);
            z_dat.push_back(z_resp_rdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic void model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] be, output logic [31:0] rd, output logic er);
        int w;
        er = (addr % 4 != 0) || (addr / 4 >= 128);
        rd = 0;
        if (er) return;
        w = int'(addr / 4);
        if (!we) begin
            rd = mem_m[w];
            return;
        end
        if (!known[w]) mem_m[w] = 0;
        for (int b = 0; b < 4; b++)
            if (be[b]) mem_m[w] = (mem_m[w] & ~(32'hFF << (8 * b))) | (wdata & (32'hFF << (8 * b)));
        known[w] = known[w] || (be == 4'hF);
    endfunction

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int stall, output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; resp_ready = 0;
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        chk("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        chk("latency", n, WC + 1);
        rd = resp_rdata;
        er = resp_err;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_valid", 32'(resp_valid), 32'd1);
        end
        resp_ready = 1;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd, erd, r0;
        logic er, eer;
        logic [31:0] addr;
        int n, w, idx;

        tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h10,       32'h11223344, 4'hF, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h10,       32'h000000AA, 4'h1, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'h112233AA, 1'b0};
        tbl[5]  = '{1'b0, 32'h13,       32'h0,        4'h0, 32'h0,        1'b1};
        tbl[6]  = '{1'b0, 32'h200,      32'h0,        4'h0, 32'h0,        1'b1};
        tbl[7]  = '{1'b1, 32'h12,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[8]  = '{1'b1, 32'h210,      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[9]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'h112233AA, 1'b0};
        tbl[10] = '{1'b1, 32'h14,       32'h55667788, 4'hF, 32'h0,        1'b0};
        tbl[11] = '{1'b1, 32'h14,       32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 32'h14,       32'h0,        4'h0, 32'h55667788, 1'b0};
        tbl[13] = '{1'b1, 32'h14,       32'hAABBCCDD, 4'hA, 32'h0,        1'b0};
        tbl[14] = '{1'b0, 32'h14,       32'h0,        4'h0, 32'hAA66CC88, 1'b0};
        tbl[15] = '{1'b1, 32'h1FC,      32'h0BADF00D, 4'hF, 32'h0,        1'b0};
        tbl[16] = '{1'b0, 32'h1FC,      32'h0,        4'h0, 32'h0BADF00D, 1'b0};
        tbl[17] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};
        tbl[18] = '{1'b1, 32'h20,       32'h13579BDF, 4'hF, 32'h0,        1'b0};
        tbl[19] = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h13579BDF, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_z_req_ready", 32'(z_req_ready), 32'd1);
        chk("rst_z_resp_valid", 32'(z_resp_valid), 32'd0);
        rst = 1;

        for (int i = 0; i < 20; i++) begin
            do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, i % 3, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].er));
            model_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, erd, eer);
            idx = int'(tbl[i].addr[8:2]);
            if (known[idx]) begin
                dbg_addr = AW'(idx);
                #1 chk($sformatf("vec%0d_dbg", i), dbg_data, mem_m[idx]);
            end
        end

        // response held while resp_ready is low; a store presented meanwhile must be ignored
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 32'h10; resp_ready = 0;
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        r0 = resp_rdata;
        chk("stall_first_data", r0, mem_m[4]);
        req_valid = 1; req_we = 1; req_wdata = 32'h0; req_be = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_rdata", resp_rdata, r0);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        dbg_addr = 7'd4;
        #1 chk("stall_store_ignored", dbg_data, mem_m[4]);
        req_valid = 0;
        resp_ready = 1;
        @(posedge clk);
        #1 req_valid = 1; req_we = 0; req_addr = 32'h14;
        n = 0;
        @(negedge clk);
        chk("release_resp_valid", 32'(resp_valid), 32'd0);
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        chk("release_gap", n, 1);
        @(posedge clk);
        #1 req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        chk("release_load", resp_rdata, mem_m[5]);
        @(posedge clk);

        // reset during the wait states of a store: store dropped, outputs cleared at once
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hFFFF0000; req_be = 4'hF;
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_resp_rdata", resp_rdata, 32'd0);
        chk("mid_rst_resp_err", 32'(resp_err), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("in_rst_resp_valid", 32'(resp_valid), 32'd0);
        end
        dbg_addr = 7'd8;
        #1 chk("mid_rst_dbg", dbg_data, 32'h13579BDF);
        rst = 1;
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        chk("after_rst_load", rd, 32'h13579BDF);

        // zero wait states: back-to-back store then load on the second instance
        @(posedge clk);
        #1 z_req_valid = 1; z_req_we = 1; z_req_addr = 32'h40; z_req_wdata = 32'hCAFEF00D; z_req_be = 4'hF;
        n = 0;
        while (z_acc.size() < 1 && n < 20) begin @(posedge clk); #1; n++; end
        z_req_we = 0; z_req_wdata = 0;
        n = 0;
        while (z_acc.size() < 2 && n < 20) begin @(posedge clk); #1; n++; end
        z_req_valid = 0;
        n = 0;
        while (z_rsp.size() < 2 && n < 20) begin @(posedge clk); #1; n++; end
        chk("z_accepts", z_acc.size(), 2);
        chk("z_responses", z_rsp.size(), 2);
        if (z_acc.size() >= 2 && z_rsp.size() >= 2) begin
            chk("z_accept_spacing", z_acc[1] - z_acc[0], 3);
            chk("z_store_latency", z_rsp[0] - z_acc[0], 1);
            chk("z_load_latency", z_rsp[1] - z_acc[1], 1);
            chk("z_store_rdata", z_dat[0], 32'h0);
            chk("z_load_rdata", z_dat[1], 32'hCAFEF00D);
        end
        z_dbg_addr = 7'd16;
        #1 chk("z_dbg", z_dbg_data, 32'hCAFEF00D);

        for (w = 0; w < 128; w++)
            if (!known[w]) begin
                addr = 32'(w) * 4;
                rd = $urandom;
                do_req(1'b1, addr, rd, 4'hF, 0, erd, er);
                model_apply(1'b1, addr, rd, 4'hF, erd, eer);
                chk("fill_err", 32'(er), 32'd0);
            end

        for (int i = 0; i < 80; i++) begin
            logic we;
            logic [31:0] wd;
            logic [3:0] be;
            int r;
            addr = 32'($urandom_range(0, 127)) * 4;
            r = int'($urandom_range(0, 15));
            if (r == 0) addr = addr + $urandom_range(1, 3);
            else if (r == 1) addr = $urandom | 32'h200;
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            be = 4'($urandom);
            do_req(we, addr, wd, be, int'($urandom_range(0, 3)), rd, er);
            model_apply(we, addr, wd, be, erd, eer);
            chk($sformatf("rnd%0d_rdata", i), rd, erd);
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(eer));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
